// File: rtl/forth_io_pkg.sv
// Shared constants for the Forth console UART: register offsets, STATUS bit
// positions and the serialiser state encoding.
package forth_io_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/forth_uart_tx_port_if.sv
// CPU data-port bus as seen by a memory-mapped peripheral: the core is the
// master, the peripheral answers with registered read data.
interface forth_uart_tx_port_if #(
  parameter int WIDTH       = 16,
  parameter int DADDR_WIDTH = 8
);
  logic [DADDR_WIDTH-1:0] daddr;
  logic [WIDTH-1:0]       ddata_write;
  logic                   dwrite;
  logic [WIDTH-1:0]       ddata_read;

  modport master (output daddr, ddata_write, dwrite, input ddata_read);
  modport slave  (input daddr, ddata_write, dwrite, output ddata_read);
endinterface

// File: rtl/forth_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push while full is accepted
// only when a pop frees the slot in the same cycle.
module forth_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/forth_uart_tx_port.sv
// Memory-mapped console port: TXDATA/STATUS/DIV register window on the CPU
// data bus, a TX FIFO, and an 8N1 serialiser driving a registered tx pin.
module forth_uart_tx_port
  import forth_io_pkg::*;
#(
  parameter int                     WIDTH       = 16,
  parameter int                     DADDR_WIDTH = 8,
  parameter logic [DADDR_WIDTH-1:0] BASE_ADDR   = DADDR_WIDTH'(8'hF0),
  parameter int                     FIFO_DEPTH  = 8,
  parameter logic [WIDTH-1:0]       DIV_RESET   = WIDTH'(16'd104)
) (
  input  logic                 clk,
  input  logic                 reset,
  forth_uart_tx_port_if.slave  bus,
  output logic                 tx,
  output logic                 tx_empty
);

  logic             hit, wr_hit;
  logic [1:0]       offset;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [WIDTH-1:0] status_word, reload;
  logic             baud_done;

  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             ovf_q, ovf_d;
  tx_state_e        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] baudcnt_q, baudcnt_d;
  logic             tx_q, tx_d;

  assign hit       = (bus.daddr[DADDR_WIDTH-1:2] == BASE_ADDR[DADDR_WIDTH-1:2]);
  assign offset    = bus.daddr[1:0];
  assign wr_hit    = bus.dwrite && hit;
  // A zero divisor behaves as one clock per bit.
  assign reload    = (div_q == '0) ? '0 : div_q - WIDTH'(1);
  assign baud_done = (baudcnt_q == '0);

  forth_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.ddata_write[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_word          = '0;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_BUSY]  = (state_q != S_IDLE);
    status_word[ST_OVF]   = ovf_q;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    fifo_push = 1'b0;
    ovf_d     = ovf_q;
    div_d     = div_q;
    rdata_d   = '0;
    if (wr_hit) begin
      unique case (offset)
        REG_TXDATA: if (!fifo_full || fifo_pop) fifo_push = 1'b1;
                    else                        ovf_d     = 1'b1;
        REG_STATUS: if (bus.ddata_write[ST_OVF]) ovf_d = 1'b0;
        REG_DIV:    div_d = bus.ddata_write;
        default:    ;
      endcase
    end
    if (hit) begin
      unique case (offset)
        REG_STATUS: rdata_d = status_word;
        REG_DIV:    rdata_d = div_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    baudcnt_d = baudcnt_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        shift_d   = fifo_dout;
        baudcnt_d = reload;
        state_d   = S_START;
      end
      S_START: if (baud_done) begin
        baudcnt_d = reload;
        bitcnt_d  = '0;
        state_d   = S_DATA;
      end else baudcnt_d = baudcnt_q - WIDTH'(1);
      S_DATA: if (baud_done) begin
        shift_d   = {1'b0, shift_q[7:1]};
        baudcnt_d = reload;
        if (bitcnt_q == 3'd7) state_d  = S_STOP;
        else                  bitcnt_d = bitcnt_q + 3'd1;
      end else baudcnt_d = baudcnt_q - WIDTH'(1);
      S_STOP: if (baud_done) begin
        // Chain straight into the next start bit when more data is queued.
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          baudcnt_d = reload;
          state_d   = S_START;
        end else state_d = S_IDLE;
      end else baudcnt_d = baudcnt_q - WIDTH'(1);
      default: state_d = S_IDLE;
    endcase
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      div_q   <= DIV_RESET;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      baudcnt_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      baudcnt_q <= baudcnt_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.ddata_read = rdata_q;
  assign tx             = tx_q;
  assign tx_empty       = fifo_empty && (state_q == S_IDLE);

endmodule

// File: tb/tb_forth_uart_tx_port.sv
// Bench for forth_uart_tx_port: expected frames and read values are queued by
// the stimulus and compared by independent UART-line and read-data monitors.
module tb_forth_uart_tx_port;

  localparam logic [7:0] BASE = 8'hF0;

  typedef struct packed {
    logic [7:0] data;
    int         p_first;   // clocks per slot for the first n_first slots
    int         n_first;
    int         p_rest;    // clocks per slot for the remaining slots
    bit         no_gap;    // start bit must follow previous stop bit directly
  } frame_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, tx_empty;
  logic rd_req = 1'b0;
  logic rd_seen = 1'b0;
  bit   abort = 1'b0;
  bit   mon_busy = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  frame_t      exp_q[$];
  logic [15:0] rd_exp_q[$];
  string       rd_nm_q[$];

  forth_uart_tx_port_if #(.WIDTH(16), .DADDR_WIDTH(8)) bus ();

  forth_uart_tx_port dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx       (tx),
    .tx_empty (tx_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.daddr = a; bus.ddata_write = d; bus.dwrite = 1'b1; rd_req = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [15:0] req, input string nm);
    @(negedge clk);
    bus.daddr = a; bus.dwrite = 1'b0; rd_req = 1'b1;
    rd_exp_q.push_back(req);
    rd_nm_q.push_back(nm);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.dwrite = 1'b0; rd_req = 1'b0; bus.daddr = 8'h00;
  endtask

  function automatic frame_t plain_frame(input logic [7:0] d, input int div, input bit gap0);
    frame_t f;
    int p = (div < 1) ? 1 : div;
    f.data = d; f.p_first = p; f.n_first = 10; f.p_rest = p; f.no_gap = gap0;
    return f;
  endfunction

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || mon_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", exp_q.size(), budget);
    end
    repeat (3) @(negedge clk);
    check("tx_empty_after_drain", tx_empty, 1);
    check("tx_idle_high", tx, 1);
  endtask

  // Read-data monitor: a read issued at an edge is compared at the next negedge.
  initial begin : rd_mon
    logic [15:0] req;
    string nm;
    forever begin
      @(posedge clk);
      rd_seen = rd_req;
      @(negedge clk);
      if (rd_seen && rd_exp_q.size() != 0) begin
        req = rd_exp_q.pop_front();
        nm  = rd_nm_q.pop_front();
        check(nm, bus.ddata_read, req);
      end
    end
  end

  // UART line monitor: samples every clock on the negedge, one slot per bit.
  initial begin : uart_mon
    frame_t     e;
    logic [9:0] lv;
    int         unstable, start_cyc, d, k;
    int         last_end = -100;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (abort || tx !== 1'b0) continue;
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_frame: start bit at cycle %0d with no byte queued", cyc);
        k = 0;
        while (tx === 1'b0 && k < 5000) begin @(negedge clk); k++; end
        continue;
      end
      e = exp_q.pop_front();
      mon_busy = 1'b1;
      unstable = 0;
      aborted  = 1'b0;
      lv       = '0;
      if (e.no_gap) check("no_idle_gap", start_cyc, last_end + 1);
      for (int s = 0; s < 10; s++) begin
        d = (s < e.n_first) ? e.p_first : e.p_rest;
        if (s > 0) @(negedge clk);
        lv[s] = tx;
        for (int j = 1; j < d; j++) begin
          @(negedge clk);
          if (tx !== lv[s]) unstable++;
        end
        if (abort) begin aborted = 1'b1; break; end
      end
      if (!aborted) begin
        check("frame_start_bit", lv[0], 0);
        check("frame_bit_timing", unstable, 0);
        check("frame_data", lv[8:1], e.data);
        check("frame_stop_bit", lv[9], 1);
      end
      last_end = cyc;
      mon_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] b;
    int div, n, gap, k;

    bus.daddr = 8'h00; bus.ddata_write = 16'h0000; bus.dwrite = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ddata_read", bus.ddata_read, 0);
    check("reset_tx", tx, 1);
    check("reset_tx_empty", tx_empty, 1);
    reset = 1'b0;

    bus_read(BASE + 8'd1, 16'h0002, "status_after_reset");
    bus_read(BASE + 8'd2, 16'd104, "div_after_reset");
    bus_idle();

    // Single 0x55 frame at 4 clocks per bit.
    bus_write(BASE + 8'd2, 16'd4);
    exp_q.push_back(plain_frame(8'h55, 4, 1'b0));
    bus_write(BASE + 8'd0, 16'hAB55);
    bus_idle();
    bus_read(BASE + 8'd2, 16'd4, "div_readback");
    bus_idle();
    wait_drain(2000);
    bus_read(BASE + 8'd1, 16'h0002, "status_after_frame");
    bus_idle();

    // Ten back-to-back writes: first goes straight to the shifter, eight fill
    // the FIFO, the tenth overflows and is dropped.
    for (int i = 0; i < 9; i++) exp_q.push_back(plain_frame(8'(i), 4, i > 0));
    for (int i = 0; i < 10; i++) bus_write(BASE + 8'd0, 16'(i));
    bus_read(BASE + 8'd1, 16'h000D, "status_full_ovf");
    bus_write(BASE + 8'd1, 16'h0008);
    bus_read(BASE + 8'd1, 16'h0005, "status_ovf_cleared");
    bus_idle();
    wait_drain(3000);

    // Two queued bytes at 2 clocks per bit, chained with no idle gap.
    bus_write(BASE + 8'd2, 16'd2);
    exp_q.push_back(plain_frame(8'hA5, 2, 1'b0));
    exp_q.push_back(plain_frame(8'h3C, 2, 1'b1));
    bus_write(BASE + 8'd0, 16'h00A5);
    bus_write(BASE + 8'd0, 16'h003C);
    bus_idle();
    wait_drain(2000);

    // DIV 4 -> 8 written in the middle of data bit 1.
    bus_write(BASE + 8'd2, 16'd4);
    begin
      frame_t f;
      f.data = 8'h96; f.p_first = 4; f.n_first = 3; f.p_rest = 8; f.no_gap = 1'b0;
      exp_q.push_back(f);
    end
    bus_write(BASE + 8'd0, 16'h0096);
    bus_idle();
    k = 0;
    while (tx !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL start_bit_timeout: tx never fell after TXDATA write");
    end
    repeat (8) @(negedge clk);
    bus_write(BASE + 8'd2, 16'd8);
    bus_idle();
    wait_drain(2000);

    // Randomised batches with random divisors, including 0.
    for (int bt = 0; bt < 4; bt++) begin
      div = $urandom_range(0, 5);
      bus_write(BASE + 8'd2, 16'(div));
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(plain_frame(b, div, 1'b0));
        bus_write(BASE + 8'd0, {8'($urandom), b});
        gap = $urandom_range(0, 3);
        if (gap > 0) begin
          bus_idle();
          repeat (gap - 1) @(negedge clk);
        end
      end
      bus_idle();
      wait_drain(3000);
    end

    // Asynchronous reset in the middle of a frame.
    abort = 1'b1;
    bus_write(BASE + 8'd2, 16'd4);
    bus_write(BASE + 8'd0, 16'h00F0);
    bus_write(BASE + 8'd0, 16'h000F);
    bus_idle();
    bus.daddr = BASE + 8'd1;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_ddata_read", bus.ddata_read, 0);
    check("async_reset_tx_empty", tx_empty, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;

    // Reserved and out-of-window accesses.
    bus_read(BASE + 8'd3, 16'h0000, "reserved_read");
    bus_read(8'hF5, 16'h0000, "miss_read_status_alias");
    bus_read(BASE + 8'd0, 16'h0000, "txdata_read");
    bus_write(BASE + 8'd3, 16'hFFFF);
    bus_write(8'hF6, 16'h00FF);
    bus_write(8'hF4, 16'h0041);
    bus_write(8'h30, 16'h0042);
    bus_read(BASE + 8'd2, 16'd104, "div_after_ignored_writes");
    bus_read(BASE + 8'd1, 16'h0002, "status_after_ignored_writes");
    bus_idle();
    repeat (20) @(negedge clk);
    wait_drain(100);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
